// File: rtl/floor_request_bank.sv
// Per-floor hall/car call latches for one elevator car, with direction-aware service
// clearing, a fire-service flush and above/here/below summaries for the dispatcher.
module floor_request_bank #(
   parameter int NFLOORS = 5,
   parameter int FW      = 3,
   parameter int CW      = 4
) (
   input  logic               ck,
   input  logic               rst_n,
   input  logic [NFLOORS-1:0] hall_up,
   input  logic [NFLOORS-1:0] hall_dn,
   input  logic [NFLOORS-1:0] car_btn,
   input  logic [FW-1:0]      cur_floor,
   input  logic               at_floor,
   input  logic [1:0]         dir,
   input  logic               flush,
   output logic [NFLOORS-1:0] up_req,
   output logic [NFLOORS-1:0] dn_req,
   output logic [NFLOORS-1:0] car_req,
   output logic [NFLOORS-1:0] pending,
   output logic               req_above,
   output logic               req_here,
   output logic               req_below,
   output logic [CW-1:0]      req_cnt,
   output logic               floor_err
);

   // Top floor has no up call and the bottom floor no down call; masking at the input
   // keeps those bits (and any X on them) out of history, latches and summaries.
   localparam logic [NFLOORS-1:0] UP_MASK = {1'b0, {(NFLOORS-1){1'b1}}};
   localparam logic [NFLOORS-1:0] DN_MASK = {{(NFLOORS-1){1'b1}}, 1'b0};

   logic [NFLOORS-1:0] up_in, dn_in;
   logic [NFLOORS-1:0] up_q, dn_q, car_q;
   logic [NFLOORS-1:0] up_edge, dn_edge, car_edge;
   logic [NFLOORS-1:0] svc_sel, up_clr, dn_clr, car_clr;
   logic               svc;

   assign up_in     = hall_up & UP_MASK;
   assign dn_in     = hall_dn & DN_MASK;
   assign up_edge   = up_in & ~up_q;
   assign dn_edge   = dn_in & ~dn_q;
   assign car_edge  = car_btn & ~car_q;

   assign floor_err = ({1'b0, cur_floor} >= (FW+1)'(NFLOORS));
   assign svc       = at_floor & ~floor_err;

   always_comb begin
      svc_sel = '0;
      for (int i = 0; i < NFLOORS; i++) begin
         svc_sel[i] = svc && (cur_floor == FW'(i));
      end
   end

   // Up calls stay latched while travelling down (and vice versa); idle/reserved clears both.
   assign car_clr = svc_sel;
   assign up_clr  = (dir == 2'b10) ? '0 : svc_sel;
   assign dn_clr  = (dir == 2'b01) ? '0 : svc_sel;

   // History tracks the buttons every cycle, flush included, so a held button never re-fires.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         up_q  <= '0;
         dn_q  <= '0;
         car_q <= '0;
      end else begin
         up_q  <= up_in;
         dn_q  <= dn_in;
         car_q <= car_btn;
      end
   end

   // Per bit: flush beats service clear beats a new press beats hold.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         up_req  <= '0;
         dn_req  <= '0;
         car_req <= '0;
      end else if (flush) begin
         up_req  <= '0;
         dn_req  <= '0;
         car_req <= '0;
      end else begin
         up_req  <= (up_req  | up_edge)  & ~up_clr;
         dn_req  <= (dn_req  | dn_edge)  & ~dn_clr;
         car_req <= (car_req | car_edge) & ~car_clr;
      end
   end

   assign pending = up_req | dn_req | car_req;

   always_comb begin
      req_above = 1'b0;
      req_here  = 1'b0;
      req_below = 1'b0;
      req_cnt   = '0;
      for (int i = 0; i < NFLOORS; i++) begin
         if (FW'(i) > cur_floor)  req_above = req_above | pending[i];
         if (FW'(i) == cur_floor) req_here  = req_here  | pending[i];
         if (FW'(i) < cur_floor)  req_below = req_below | pending[i];
         req_cnt = req_cnt + CW'(up_req[i]) + CW'(dn_req[i]) + CW'(car_req[i]);
      end
      if (floor_err) begin
         req_above = 1'b0;
         req_here  = 1'b0;
         req_below = 1'b0;
      end
   end

endmodule

// File: doc/floor_request_bank.md
Name: floor_request_bank

Overview:
- Parametrised elevator request register bank for NFLOORS floors.
- Captures hall-up, hall-down and car-button presses on rising edges into per-floor latches.
- Clears latches direction-aware when the car services a floor.
- Exports per-floor pending vectors, above/here/below summaries relative to the current floor, and a request count for the dispatch controller.
- Supports a fire-service flush.

Parameters:
- NFLOORS, 5, number of floors (2..32); floor index 0 is the lowest floor.
- FW, 3, floor index width; must satisfy 2^FW >= NFLOORS.
- CW, 4, request count width; must satisfy 2^CW > 3*NFLOORS.

Ports:
- ck  in  1  system clock, rising edge.
- rst_n  in  1  reset; clears all state.
- hall_up  in  NFLOORS  hall up buttons, level; bit NFLOORS-1 ignored.
- hall_dn  in  NFLOORS  hall down buttons, level; bit 0 ignored.
- car_btn  in  NFLOORS  in-car floor buttons, level.
- cur_floor  in  FW  current car floor index.
- at_floor  in  1  car stopped at cur_floor with doors opening; service strobe, level.
- dir  in  2  travel direction: 00 idle, 01 up, 10 down, 11 reserved (treated as idle).
- flush  in  1  fire service; clears all latches and blocks capture while high.
- up_req  out  NFLOORS  latched hall-up calls.
- dn_req  out  NFLOORS  latched hall-down calls.
- car_req  out  NFLOORS  latched car calls.
- pending  out  NFLOORS  up_req | dn_req | car_req.
- req_above  out  1  any pending bit at index > cur_floor.
- req_here  out  1  pending[cur_floor].
- req_below  out  1  any pending bit at index < cur_floor.
- req_cnt  out  CW  popcount of up_req, dn_req and car_req concatenated.
- floor_err  out  1  cur_floor >= NFLOORS.

Behaviour:
- Clock and reset: one clock, ck; rst_n asynchronous, active-low.
- Reset: up_req, dn_req, car_req and the three button-history registers go to 0.
  - Derived outputs at reset: pending 0, req_above/req_here/req_below 0, req_cnt 0; floor_err follows cur_floor.
- Edge detection: each button input has a history register updated every edge, including during flush.
  - edge = btn & ~btn_q.
  - A held button sets its latch once only. Re-press requires release for at least 1 sampled cycle.
- Set latency: a press first sampled high at edge k gives latch = 1 after edge k.
  - Ignored bits (hall_up[NFLOORS-1], hall_dn[0]) never set.
- Service clear, when at_floor=1 and floor_err=0, at floor f=cur_floor:
  - car_req[f] cleared always.
  - up_req[f] cleared if dir is 01, 00 or 11.
  - dn_req[f] cleared if dir is 10, 00 or 11.
  - Clears repeat every cycle at_floor stays high.
- Priority, per bit: flush > service clear > set > hold.
  - A press edge in the same cycle as a clear of that bit is lost, by design: the car is at the floor.
  - A press at a different floor in the same cycle is captured.
- flush: all latches 0 after the first edge with flush=1. No sets while flush=1.
  - Buttons held through flush deassert do not set, because history is up to date.
- floor_err=1:
  - No service clears.
  - req_above, req_here, req_below forced 0.
  - Latching of new presses continues normally.
- Summary outputs: req_above, req_here, req_below, pending, req_cnt and floor_err are combinational from the registered latches and cur_floor.
  - No added latency beyond the latch edge.
- Boundaries:
  - cur_floor=0 gives req_below=0.
  - cur_floor=NFLOORS-1 gives req_above=0.
  - req_cnt maximum is 3*NFLOORS-2 (ignored bits never set).
- Reset mid-operation: immediate clear of all state. After release, buttons still held are seen as new edges, since history is 0.
- Unused inputs bits are X-safe: ignored bits must not propagate X into outputs.

Test Plan:
- Reset, then pulse hall_up[1] one cycle at NFLOORS=5 -> up_req=00010 after that edge; req_cnt=1; with cur_floor=3: req_below=1, req_above=0, req_here=0.
- Hold car_btn[4] 10 cycles; at cur_floor=4, at_floor=1, dir=00 for 1 cycle; keep button held -> car_req[4]=1 then 0, stays 0 while held; release 1 cycle and re-press -> sets again.
- hall_up[2] and hall_dn[2] latched; cur_floor=2, at_floor=1, dir=01 -> up_req[2]=0, dn_req[2]=1, req_here=1. Repeat with dir=10 -> dn_req[2]=0.
- Same cycle: at_floor=1 at floor 3 plus new edges on car_btn[3] and car_btn[0] -> car_req[3]=0, car_req[0]=1.
- Set 6 assorted calls (req_cnt=6); assert flush 3 cycles while holding hall_dn[4] -> all latches 0 after first flush edge, req_cnt=0; after deassert, hall_dn[4] stays 0 until re-pressed.
- Press hall_up[4] and hall_dn[0] -> no change. cur_floor=6 with at_floor=1 and car_req[1] set -> floor_err=1, car_req[1] stays 1, req_above/req_here/req_below=0. Assert rst_n=0 asynchronously mid-cycle -> all latches 0 immediately.
